// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: event-kind codes and channel FSM states shared by the button event arbiter
package btn_evt_pkg;
    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_REPEAT  = 2'd2;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } ch_state_t;
endpackage

// File: rtl/btn_channel_fsm.sv
// btn_channel_fsm: edge detect, hold/repeat timing and a one-entry pending event slot for one button
module btn_channel_fsm
    import btn_evt_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int HOLD_CYCLES   = 50000,
    parameter int REPEAT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_btn,
    input  logic       i_consume,
    output logic       o_pend_valid,
    output logic [1:0] o_pend_kind,
    output logic       o_ovf
);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    ch_state_t        r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_btn_q, w_rise, w_post, r_pv, r_ovf;
    logic [1:0]       w_kind, r_pk;
    assign w_rise       = i_btn & ~r_btn_q;
    assign o_pend_valid = r_pv;
    assign o_pend_kind  = r_pk;
    assign o_ovf        = r_ovf;
    always_ff @(posedge clk) begin
        r_btn_q <= i_btn;
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
        end
    end
    // A low level while pressed is a release even if the falling edge was never seen
    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt + 1'b1;
        case (r_state)
            IDLE: begin
                w_cnt  = '0;
                w_next = w_rise ? HOLD : IDLE;
            end
            HOLD: begin
                if (!i_btn) begin
                    w_next = IDLE;
                    w_cnt  = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_next = RPT;
                    w_cnt  = '0;
                end
            end
            RPT: begin
                if (!i_btn) begin
                    w_next = IDLE;
                    w_cnt  = '0;
                end else if (r_cnt == RPT_LAST) begin
                    w_cnt = '0;
                end
            end
            default: begin
                w_next = IDLE;
                w_cnt  = '0;
            end
        endcase
    end
    always_comb begin
        w_post = 1'b0;
        w_kind = EVT_PRESS;
        case (r_state)
            IDLE: w_post = w_rise;
            HOLD, RPT: begin
                w_post = !i_btn || r_cnt == (r_state == HOLD ? HOLD_LAST : RPT_LAST);
                w_kind = !i_btn ? EVT_RELEASE : EVT_REPEAT;
            end
            default: w_post = 1'b0;
        endcase
    end
    // A post in the same cycle as a transfer replaces the departing entry without overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pv  <= 1'b0;
            r_pk  <= EVT_PRESS;
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_post & r_pv & ~i_consume;
            if (w_post) begin
                r_pv <= 1'b1;
                r_pk <= w_kind;
            end else if (i_consume) begin
                r_pv <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: per-button PRESS/RELEASE/REPEAT events shared on one valid/ready channel via round-robin
module button_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter int N             = 4,
    parameter int CNT_W         = 16,
    parameter int HOLD_CYCLES   = 50000,
    parameter int REPEAT_CYCLES = 10000,
    localparam int IDW          = $clog2(N) > 1 ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   btn,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [IDW-1:0] evt_id,
    output logic [1:0]     evt_kind,
    output logic           overflow
);
    logic [N-1:0]   w_pv, w_consume, w_ovf;
    logic [1:0]     w_pk [N];
    logic [IDW-1:0] r_ptr, r_id, w_win, w_idx;
    logic [1:0]     r_kind;
    logic           r_valid, w_found, w_load;
    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_ch
            btn_channel_fsm #(
                .CNT_W        (CNT_W),
                .HOLD_CYCLES  (HOLD_CYCLES),
                .REPEAT_CYCLES(REPEAT_CYCLES)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_btn       (btn[g]),
                .i_consume   (w_consume[g]),
                .o_pend_valid(w_pv[g]),
                .o_pend_kind (w_pk[g]),
                .o_ovf       (w_ovf[g])
            );
            assign w_consume[g] = w_load & w_found & (w_win == IDW'(g));
        end
    endgenerate
    assign w_load    = ~r_valid | evt_ready;
    assign evt_valid = r_valid;
    assign evt_id    = r_id;
    assign evt_kind  = r_kind;
    assign overflow  = |w_ovf;
    // Scanning downward lets the slot closest to ptr win the last assignment
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = IDW'((int'(r_ptr) + k) % N);
            if (w_pv[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_kind  <= EVT_PRESS;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_valid <= w_found;
            if (w_found) begin
                r_id   <= w_win;
                r_kind <= w_pk[w_win];
                r_ptr  <= (w_win == IDW'(N - 1)) ? '0 : w_win + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed scenarios plus randomized traffic against an event-level reference model
module tb_button_event_arbiter;
    import btn_evt_pkg::*;
    localparam int N = 4, HOLD = 8, REP = 4;
    logic clk = 1'b0, rst_n = 1'b0, evt_ready = 1'b0, evt_valid, overflow;
    logic [N-1:0] btn = '0;
    logic [1:0] evt_id, evt_kind;
    int n_cmp = 0, n_fail = 0;
    int unsigned now = 0;
    bit m_held[N], m_prev[N], m_pv[N];
    int unsigned m_start[N];
    logic [1:0] m_pk[N];
    bit m_valid = 1'b0, m_ovf = 1'b0;
    int m_id = 0, m_ptr = 0;
    logic [1:0] m_kind = 2'd0;

    button_event_arbiter #(.N(N), .CNT_W(16), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_id(evt_id), .evt_kind(evt_kind), .overflow(overflow));

    always #5 clk = ~clk;

    // Event-level model: held buttons emit REPEAT when the time since press hits HOLD, HOLD+REP, ...
    task automatic model_edge();
        bit post[N];
        logic [1:0] pk[N];
        int win;
        now++;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_held[i] = 0; m_pv[i] = 0; m_prev[i] = btn[i];
            end
            m_valid = 0; m_id = 0; m_kind = EVT_PRESS; m_ovf = 0; m_ptr = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            post[i] = 0; pk[i] = EVT_PRESS;
            if (!m_held[i] && btn[i] && !m_prev[i]) begin
                post[i] = 1; pk[i] = EVT_PRESS; m_held[i] = 1; m_start[i] = now;
            end else if (m_held[i] && !btn[i]) begin
                post[i] = 1; pk[i] = EVT_RELEASE; m_held[i] = 0;
            end else if (m_held[i] && now - m_start[i] >= HOLD && (now - m_start[i] - HOLD) % REP == 0) begin
                post[i] = 1; pk[i] = EVT_REPEAT;
            end
            m_prev[i] = btn[i];
        end
        m_ovf = 0;
        if (!m_valid || evt_ready) begin
            win = -1;
            for (int k = 0; k < N; k++)
                if (win < 0 && m_pv[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            m_valid = (win >= 0);
            if (win >= 0) begin
                m_id = win; m_kind = m_pk[win]; m_pv[win] = 0; m_ptr = (win + 1) % N;
            end
        end
        for (int i = 0; i < N; i++)
            if (post[i]) begin
                if (m_pv[i]) m_ovf = 1;
                m_pv[i] = 1; m_pk[i] = pk[i];
            end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset(input logic [N-1:0] b);
        rst_n = 0; btn = b;
        step(); step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        evt_ready = 1;
        apply_reset(4'b0010);
        n_cmp++;
        if ({evt_valid, evt_id, evt_kind, overflow} !== 6'b0) begin
            n_fail++; $display("FAIL reset_vals: got v=%b id=%0d k=%0d ovf=%b want all 0", evt_valid, evt_id, evt_kind, overflow);
        end
        for (int c = 0; c < 100; c++) begin
            step();
            n_cmp++;
            if (evt_valid !== 1'b0 || overflow !== 1'b0 || m_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_held_quiet c=%0d: got v=%b ovf=%b model_v=%b want 0", c, evt_valid, overflow, m_valid);
            end
        end
    endtask

    task automatic test_press_release();
        apply_reset('0);
        evt_ready = 1;
        btn[2] = 1;
        step();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL press_latency: got v=%b want 0 at edge k", evt_valid);
        end
        step();
        n_cmp++;
        if ({evt_valid, evt_id, evt_kind} !== {1'b1, 2'd2, EVT_PRESS}) begin
            n_fail++; $display("FAIL press_evt: got v=%b id=%0d k=%0d want v=1 id=2 k=0", evt_valid, evt_id, evt_kind);
        end
        step();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL press_one_cycle: got v=%b want 0", evt_valid);
        end
        repeat (3) step();
        btn[2] = 0;
        step(); step();
        n_cmp++;
        if ({evt_valid, evt_id, evt_kind} !== {1'b1, 2'd2, EVT_RELEASE}) begin
            n_fail++; $display("FAIL release_evt: got v=%b id=%0d k=%0d want v=1 id=2 k=1", evt_valid, evt_id, evt_kind);
        end
    endtask

    task automatic test_hold_repeat();
        int t_press = -1, t_rel = -1;
        int t_rep[$];
        apply_reset('0);
        evt_ready = 1;
        btn[0] = 1;
        for (int c = 0; c < 40; c++) begin
            if (c == 21) btn[0] = 0;
            step();
            n_cmp++;
            if ({evt_valid, evt_id, evt_kind} !== {m_valid, 2'(m_id), m_kind}) begin
                n_fail++; $display("FAIL hold_model c=%0d: got v=%b id=%0d k=%0d want v=%b id=%0d k=%0d", c, evt_valid, evt_id, evt_kind, m_valid, m_id, m_kind);
            end
            if (evt_valid === 1'b1) begin
                if (evt_kind == EVT_PRESS) t_press = c;
                else if (evt_kind == EVT_REPEAT) t_rep.push_back(c);
                else if (evt_kind == EVT_RELEASE) t_rel = c;
            end
        end
        n_cmp++;
        if (t_rep.size() != 4 || t_press != 1 || t_rel != 22) begin
            n_fail++; $display("FAIL hold_counts: got repeats=%0d press_t=%0d rel_t=%0d want 4/1/22", t_rep.size(), t_press, t_rel);
        end else begin
            n_cmp++;
            if (t_rep[0] - t_press != HOLD || t_rep[1] - t_rep[0] != REP || t_rep[3] - t_rep[2] != REP) begin
                n_fail++; $display("FAIL hold_spacing: got first=%0d gaps=%0d,%0d want %0d,%0d", t_rep[0] - t_press, t_rep[1] - t_rep[0], t_rep[3] - t_rep[2], HOLD, REP);
            end
        end
    endtask

    task automatic test_burst();
        apply_reset('0);
        evt_ready = 1;
        btn = 4'b1111;
        step();
        for (int i = 0; i < N; i++) begin
            step();
            n_cmp++;
            if ({evt_valid, evt_id, evt_kind} !== {1'b1, 2'(i), EVT_PRESS}) begin
                n_fail++; $display("FAIL burst_press %0d: got v=%b id=%0d k=%0d want v=1 id=%0d k=0", i, evt_valid, evt_id, evt_kind, i);
            end
        end
        btn = 4'b0000;
        step();
        for (int i = 0; i < N; i++) begin
            step();
            n_cmp++;
            if ({evt_valid, evt_id, evt_kind} !== {1'b1, 2'(i), EVT_RELEASE}) begin
                n_fail++; $display("FAIL burst_release %0d: got v=%b id=%0d k=%0d want v=1 id=%0d k=1", i, evt_valid, evt_id, evt_kind, i);
            end
        end
    endtask

    task automatic test_backpressure();
        int n_ovf = 0;
        apply_reset('0);
        evt_ready = 0;
        btn[1] = 1;
        step(); step();
        for (int c = 0; c < 4; c++) begin
            btn[3] = (c == 0);
            step();
            n_ovf += int'(overflow === 1'b1);
            n_cmp++;
            if ({evt_valid, evt_id, evt_kind} !== {1'b1, 2'd1, EVT_PRESS}) begin
                n_fail++; $display("FAIL bp_stable c=%0d: got v=%b id=%0d k=%0d want v=1 id=1 k=0", c, evt_valid, evt_id, evt_kind);
            end
        end
        n_cmp++;
        if (n_ovf != 1) begin
            n_fail++; $display("FAIL bp_overflow: got %0d pulses want 1", n_ovf);
        end
        evt_ready = 1;
        step();
        n_cmp++;
        if ({evt_valid, evt_id, evt_kind} !== {1'b1, 2'd3, EVT_RELEASE}) begin
            n_fail++; $display("FAIL bp_drain: got v=%b id=%0d k=%0d want v=1 id=3 k=1", evt_valid, evt_id, evt_kind);
        end
        btn[1] = 0;
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        apply_reset('0);
        evt_ready = 0;
        btn = 4'b0111;
        step(); step();
        n_cmp++;
        if (evt_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: got v=%b want 1", evt_valid);
        end
        rst_n = 0;
        step();
        n_cmp++;
        if ({evt_valid, overflow} !== 2'b00) begin
            n_fail++; $display("FAIL mid_reset: got v=%b ovf=%b want 0 0", evt_valid, overflow);
        end
        rst_n = 1;
        evt_ready = 1;
        for (int c = 0; c < 20; c++) begin
            step();
            n_cmp++;
            if (evt_valid !== 1'b0) begin
                n_fail++; $display("FAIL mid_stale c=%0d: got v=%b want 0", c, evt_valid);
            end
        end
        btn = '0;
        step();
    endtask

    task automatic test_random();
        apply_reset(4'($urandom));
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) btn[$urandom_range(0, N - 1)] ^= 1'b1;
            evt_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
            n_cmp++;
            if ({evt_valid, evt_id, evt_kind, overflow} !== {m_valid, 2'(m_id), m_kind, m_ovf}) begin
                n_fail++; $display("FAIL random c=%0d: got v=%b id=%0d k=%0d ovf=%b want v=%b id=%0d k=%0d ovf=%b", c, evt_valid, evt_id, evt_kind, overflow, m_valid, m_id, m_kind, m_ovf);
            end
        end
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_hold_repeat();
        test_burst();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Collects debounced button levels from N per-button debouncer instances and converts them into discrete PRESS/RELEASE/REPEAT events.
- Holding a button produces REPEAT events after a hold delay.
- Shares a single event output channel between all buttons using round-robin arbitration and a valid/ready handshake.
- Sits between the debouncer bank and menu/UI control logic.

Parameters:
- N, 4, number of button channels (2..16).
- CNT_W, 16, width of the hold/repeat counters.
- HOLD_CYCLES, 50000, cycles a button must stay high before the first REPEAT (2..2^CNT_W-1).
- REPEAT_CYCLES, 10000, cycles between successive REPEAT events while held (1..2^CNT_W-1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- btn  in  N  debounced button levels, already synchronous to clk.
- evt_valid  out  1  event available on evt_id/evt_kind.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready at a clk edge.
- evt_id  out  IDW  channel index of the event; IDW = max(1,$clog2(N)).
- evt_kind  out  2  event kind: 0 PRESS, 1 RELEASE, 2 REPEAT (3 never driven).
- overflow  out  1  one-cycle pulse: an unconsumed pending event was overwritten.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - evt_valid=0, evt_id=0, evt_kind=0, overflow=0.
  - All pending slots cleared, all channel FSMs to IDLE, counters 0, round-robin pointer 0.
  - btn_q <= btn, so buttons held during reset produce no PRESS.
  - Reset mid-handshake drops the offered event.
- Edge detection per channel i:
  - rise = btn[i] & ~btn_q[i]; fall = ~btn[i] & btn_q[i]; btn_q updates every cycle.
- Per-channel FSM:
  - IDLE: on rise -> HOLD, cnt=0, post PRESS.
  - HOLD: on fall -> IDLE, post RELEASE. Else if cnt==HOLD_CYCLES-1 -> RPT, cnt=0, post REPEAT. Else cnt++.
  - RPT: on fall -> IDLE, post RELEASE. Else if cnt==REPEAT_CYCLES-1 -> cnt=0, post REPEAT. Else cnt++.
  - A channel in HOLD/RPT that sees btn low without a detected fall cannot occur; if it does, treat it as fall.
- Pending slot per channel: one entry {valid, kind}.
  - A post sets valid and writes kind.
  - If the slot is already valid and is not being transferred to the output this cycle, the new kind overwrites it and overflow pulses for one cycle.
  - If transfer and post happen in the same cycle on the same channel, the old entry leaves, the new entry stays pending, and there is no overflow.
- Output register:
  - Loads when evt_valid==0 or (evt_valid && evt_ready).
  - Winner: first valid slot scanning from ptr upward, modulo N. Loading clears that slot and sets ptr = winner+1 (wraps N-1 -> 0).
  - If no slot is valid, evt_valid goes 0 (only when the load condition is true).
  - While evt_valid && !evt_ready, evt_valid, evt_id and evt_kind hold stable.
- Latency: a btn change before clk edge k sets the pending slot at edge k; evt_valid rises at edge k+1 when the output is free.
- Throughput: one event per cycle while evt_ready=1.
- Fairness: with all N slots pending and evt_ready=1, events are delivered in order ptr, ptr+1, …, wrapping.

Decomposition:
- Shared package btn_evt_pkg holds:
  - Event-kind constants EVT_PRESS=2'd0, EVT_RELEASE=2'd1, EVT_REPEAT=2'd2.
  - Channel FSM state encodings IDLE/HOLD/RPT (2 bits).
- One sub-module: btn_channel_fsm.
  - Contains edge detect, FSM, counter and pending slot.
  - Instantiated N times; inputs are btn bit, grant/consume strobe; outputs are pend_valid, pend_kind, ovf.
- The top holds the round-robin arbiter, output register and overflow OR.

Test Plan:
- Reset with btn=4'b0010 held, release rst_n, keep btn constant 100 cycles -> evt_valid stays 0, overflow 0.
- evt_ready=1; btn[2] 0->1 before edge k -> evt_valid=1, evt_id=2, evt_kind=0 after edge k+1 for one cycle. btn[2] 1->0 later -> evt_kind=1 event.
- HOLD_CYCLES=8, REPEAT_CYCLES=4; hold btn[0] for 20 cycles with evt_ready=1 -> PRESS, REPEAT 8 cycles after the press is registered, further REPEATs every 4 cycles, RELEASE after the fall; exactly 4 REPEATs.
- btn 4'b0000 -> 4'b1111 in one cycle, evt_ready=1, ptr=0 -> PRESS events with evt_id 0,1,2,3 on consecutive cycles. A second simultaneous release burst with ptr now 0 again -> RELEASE ids 0,1,2,3.
- evt_ready=0 with event id 1 offered; press/release btn[3] twice -> evt_valid/id/kind stable throughout, overflow pulses once (second post overwrites), then evt_ready=1 -> id 1 then id 3 with evt_kind=RELEASE.
- rst_n asserted while evt_valid=1 and evt_ready=0 with pending slots -> next cycle evt_valid=0; no stale events after reset deasserts.
